// File: rtl/alu_normalizer.sv
//-----------------------------------------------------------------------------
// alu_normalizer
//
// Sequential normalizer that sits beside the shift ALU. For a captured operand
// it finds the shift count that moves the most significant set bit to bit
// WIDTH-1 (dir=0, leading-zero count) or the least significant set bit to
// bit 0 (dir=1, trailing-zero count), and returns that count together with the
// normalized value. The controller can feed Cnt straight back to the shift ALU
// in the opposite direction to recover the original operand.
//
// Optional build macro:
//   ALU_NORM_SKIP2_EN - when defined, the SHIFT state moves two positions per
//                       cycle whenever the target bit and its neighbour are
//                       both clear. Results (S, Cnt, Z) are unchanged; only
//                       latency shrinks.
//
// Parameters:
//   WIDTH  operand width in bits (>= 2)
//   CW     count width, $clog2(WIDTH), derived
//
// Ports:
//   clk    in   rising-edge clock
//   rst    in   synchronous active-high reset
//   start  in   request, sampled only while busy=0
//   dir    in   0 = normalize toward MSB, 1 = toward LSB; sampled with start
//   A      in   operand; sampled with start
//   busy   out  high from the accepting edge until the completing edge
//   done   out  one-cycle pulse, result valid
//   S      out  normalized value (holds until next completion or reset)
//   Cnt    out  number of positions shifted
//   Z      out  operand was zero
//-----------------------------------------------------------------------------
module alu_normalizer #(
    parameter  int WIDTH = 8,
    localparam int CW    = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             dir,
    input  logic [WIDTH-1:0] A,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] S,
    output logic [CW-1:0]    Cnt,
    output logic             Z
);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_reg;
    logic [CW-1:0]    r_cnt;
    logic             r_dir;
    logic             r_done;
    logic [WIDTH-1:0] r_s;
    logic [CW-1:0]    r_cnt_o;
    logic             r_z;

    state_t           w_state_nxt;
    logic [WIDTH-1:0] w_reg_nxt;
    logic [CW-1:0]    w_cnt_nxt;
    logic             w_dir_nxt;
    logic             w_done_nxt;
    logic [WIDTH-1:0] w_s_nxt;
    logic [CW-1:0]    w_cnt_o_nxt;
    logic             w_z_nxt;

    logic             w_tgt;
    logic             w_zero;
    logic [WIDTH-1:0] w_shift1;

    // Bit that must become 1 for the operand to count as normalized.
    assign w_tgt    = r_dir ? r_reg[0] : r_reg[WIDTH-1];
    assign w_zero   = (r_reg == '0);
    assign w_shift1 = r_dir ? (r_reg >> 1) : (r_reg << 1);

`ifdef ALU_NORM_SKIP2_EN
    logic             w_nbr;
    logic [WIDTH-1:0] w_shift2;

    // With the target and its neighbour both clear (and reg nonzero) the set
    // bit is at least two positions away, so a double step cannot overshoot.
    assign w_nbr    = r_dir ? r_reg[1] : r_reg[WIDTH-2];
    assign w_shift2 = r_dir ? (r_reg >> 2) : (r_reg << 2);
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_reg_nxt   = r_reg;
        w_cnt_nxt   = r_cnt;
        w_dir_nxt   = r_dir;
        w_done_nxt  = 1'b0;
        w_s_nxt     = r_s;
        w_cnt_o_nxt = r_cnt_o;
        w_z_nxt     = r_z;

        case (r_state)
            IDLE: begin
                if (start) begin
                    w_reg_nxt   = A;
                    w_cnt_nxt   = '0;
                    w_dir_nxt   = dir;
                    w_state_nxt = SHIFT;
                end
            end

            SHIFT: begin
                if (w_tgt || w_zero) begin
                    w_s_nxt     = r_reg;
                    w_cnt_o_nxt = r_cnt;
                    w_z_nxt     = w_zero;
                    w_done_nxt  = 1'b1;
                    w_state_nxt = IDLE;
                end else begin
`ifdef ALU_NORM_SKIP2_EN
                    if (!w_nbr) begin
                        w_reg_nxt = w_shift2;
                        w_cnt_nxt = r_cnt + CW'(2);
                    end else begin
                        w_reg_nxt = w_shift1;
                        w_cnt_nxt = r_cnt + CW'(1);
                    end
`else
                    w_reg_nxt = w_shift1;
                    w_cnt_nxt = r_cnt + CW'(1);
`endif
                end
            end

            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_reg   <= '0;
            r_cnt   <= '0;
            r_dir   <= 1'b0;
            r_done  <= 1'b0;
            r_s     <= '0;
            r_cnt_o <= '0;
            r_z     <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_reg   <= w_reg_nxt;
            r_cnt   <= w_cnt_nxt;
            r_dir   <= w_dir_nxt;
            r_done  <= w_done_nxt;
            r_s     <= w_s_nxt;
            r_cnt_o <= w_cnt_o_nxt;
            r_z     <= w_z_nxt;
        end
    end

    // busy is exactly "in SHIFT": set by the accepting edge, cleared by the
    // completing edge, which also lets start be accepted during the done cycle.
    assign busy = (r_state == SHIFT);
    assign done = r_done;
    assign S    = r_s;
    assign Cnt  = r_cnt_o;
    assign Z    = r_z;

endmodule

// File: doc/alu_normalizer.md
Name: alu_normalizer

Overview:
- Sequential normalizer for the 8-bit datapath; the inverse of the shifter ALU.
- The shifter takes a value and a count and produces a shifted value. This block takes a value and produces the shift count that normalizes it, plus the normalized value.
- Left mode brings the most significant set bit to bit WIDTH-1 (leading-zero count). Right mode brings the least significant set bit to bit 0 (trailing-zero count).
- Sits beside the shift ALU. The controller feeds the resulting count straight back as that unit's Cnt operand for denormalization.

Parameters:
- WIDTH, 8, operand width in bits; must be >= 2.
- CW, $clog2(WIDTH), width of the count output; derived, never overridden.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- start  input  1  request; sampled only when busy=0
- dir  input  1  0 = normalize left (MSB), 1 = normalize right (LSB); sampled with start
- A  input  WIDTH  operand; sampled with start
- busy  output  1  high from the edge that accepts start until the edge that completes
- done  output  1  one-cycle pulse, result valid
- S  output  WIDTH  normalized value
- Cnt  output  CW  number of positions shifted
- Z  output  1  operand was zero

Behaviour:
- Reset (rst=1 at an edge, any state): state<=IDLE, busy=0, done=0, S=0, Cnt=0, Z=0, internal reg and counter cleared. A reset mid-operation abandons the operation; no done is produced.
- States: IDLE, SHIFT.
- IDLE:
  - start=1 at an edge: reg<=A, cnt<=0, dir_q<=dir, state<=SHIFT, busy<=1.
  - done is low in every cycle except the completion pulse.
- SHIFT, per edge:
  - Target bit is reg[WIDTH-1] when dir_q=0, reg[0] when dir_q=1.
  - Target bit =1 or reg==0: S<=reg, Cnt<=cnt, Z<=(reg==0), done<=1 for exactly one cycle, busy<=0, state<=IDLE.
  - Otherwise: reg shifts one position toward the target (zero fill) and cnt<=cnt+1.
- Shift count bound: a nonzero operand reaches the target within WIDTH-1 shifts, so cnt never exceeds WIDTH-1 and cannot wrap.
- Zero operand: S=0, Cnt=0, Z=1.
- Latency: for a result count n, done is high in the cycle following edge k+n+1, where edge k accepted start.
  - Minimum 2 cycles.
  - Maximum WIDTH+1 cycles (WIDTH-1 shifts).
- start while busy=1: ignored; A and dir are not sampled.
- start in the same cycle done is high: accepted, because state is already IDLE. Back-to-back throughput has no dead cycle.
- S, Cnt, Z hold their last result until the next completion or reset. They do not change during SHIFT.
- Invariant (verification): feeding S back through the shift ALU in the opposite direction by Cnt (left mode: shift right; right mode: shift left) reproduces A exactly.

Optional Feature:
- Macro: ALU_NORM_SKIP2_EN.
- When defined, in SHIFT:
  - If the target bit and its neighbour (reg[WIDTH-2] for left, reg[1] for right) are both 0 and reg!=0: shift 2 positions, cnt<=cnt+2.
  - If only the target bit is 0: shift 1, as in the base behaviour.
  - Completion conditions are unchanged.
- Result values S, Cnt and Z are identical with and without the macro; only latency shrinks.
  - Worst case with WIDTH=8: 4 shift cycles instead of 7.
- When undefined: strictly one position per cycle, as specified above.

Test Plan:
- A=0x13, dir=0, start -> after 3 shifts: done pulse with S=0x98, Cnt=3, Z=0; done 5 cycles after start, busy high for 4 cycles.
- A=0x28, dir=1 -> S=0x05, Cnt=3, Z=0. Then A=0x80, dir=0 -> S=0x80, Cnt=0, done 2 cycles after start.
- A=0x00, dir=0 and dir=1 -> S=0x00, Cnt=0, Z=1, done after 2 cycles. A=0x01, dir=0 -> S=0x80, Cnt=7, done after 9 cycles (6 with ALU_NORM_SKIP2_EN).
- During busy, pulse start with A=0xFF -> ignored; the in-flight result (A=0x13 -> Cnt=3) is unchanged. Assert start in the done cycle with A=0x40, dir=0 -> accepted, Cnt=1, S=0x80.
- Assert rst on the second SHIFT cycle of A=0x01 -> next cycle busy=0, done=0, S=0, Cnt=0, Z=0; no done pulse follows.
- Exhaustive A=0x00..0xFF, both dir, both macro settings -> Cnt equals leading/trailing zero count (0 for A=0). Shifting S back by Cnt in the opposite direction equals A; the shift-back check applies to all nonzero A.
